muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller that owns the HI/LO register pair.
- Sits beside the EXE stage. ID/EXE launches MULT/MULTU/DIV/DIVU; the decode stage reads HI/LO for MFHI/MFLO and writes them for MTHI/MTLO.
- Sequences an iterative 32-step shift-add / restoring-divide datapath.
- Raises a stall so the pipeline holds any HI/LO access while an operation is in flight.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- COUNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Start_IN  in  1  launch request, sampled at the rising edge.
- Op_IN  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA_IN  in  32  rs value (multiplicand / dividend).
- OperandB_IN  in  32  rt value (multiplier / divisor).
- WriteHi_IN  in  1  MTHI write enable.
- WriteLo_IN  in  1  MTLO write enable.
- WriteData_IN  in  32  MTHI/MTLO data.
- ReadRequest_IN  in  1  decode stage holds an MFHI/MFLO.
- Hi_OUT  out  32  HI register.
- Lo_OUT  out  32  LO register.
- Busy_OUT  out  1  operation in flight.
- Stall_OUT  out  1  pipeline must hold the current HI/LO access.
- Done_OUT  out  1  one-cycle pulse: HI/LO just updated by an operation.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, counter=0, HI=LO=0.
  - Busy_OUT=0, Done_OUT=0.
  - Internal accumulators cleared; an in-flight operation is abandoned.
- States: IDLE, PREP, RUN, FIXUP.
- IDLE:
  - Start_IN=1 latches Op, A, B → PREP.
  - WriteHi_IN/WriteLo_IN write WriteData_IN into HI/LO on the same edge.
  - If Start and a write coincide, both are applied; the operation result overwrites HI/LO at FIXUP.
- PREP (1 cycle):
  - Signed ops: take magnitudes of A and B; record negQ=signA^signB and negR=signA.
  - Unsigned ops: negQ=negR=0.
  - Counter loads DATA_WIDTH. → RUN.
- RUN (exactly 32 cycles), one iteration per cycle; counter decrements, → FIXUP when it reaches 0.
  - Multiply: 64-bit {acc,mplier} shift-add.
  - Divide: restoring subtract on {rem,quot}.
- FIXUP (1 cycle), writes HI/LO → IDLE; Done_OUT=1 in the following cycle only.
  - Multiply: {HI,LO} = product, two's-complement negated if negQ.
  - Divide: LO = quotient (negated if negQ); HI = remainder (negated if negR).
- Latency:
  - Start accepted at edge t.
  - Busy_OUT=1 for cycles t+1..t+34.
  - New HI/LO visible and Done_OUT=1 in cycle t+35; Busy_OUT=0 that cycle.
- Stall_OUT = Busy_OUT & (ReadRequest_IN | Start_IN | WriteHi_IN | WriteLo_IN), combinational.
  - While Busy_OUT=1, Start/WriteHi/WriteLo are ignored; the pipeline retries them.
  - Hi_OUT/Lo_OUT are the architectural registers; they show old values while busy.
- Divide by zero (B=0, DIV or DIVU):
  - Full 35-cycle latency.
  - LO=0xFFFFFFFF, HI=OperandA_IN (raw dividend). Sign fixup is not applied.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, with no trap.
- Magnitude of 0x80000000 is computed in 33 bits or as unsigned 32-bit, so no overflow.
- Op_IN, OperandA_IN and OperandB_IN are ignored outside the Start edge.

Decomposition:
- Package muldiv_pkg:
  - Op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State encodings.
  - DATA_WIDTH / COUNT_WIDTH defaults.
  - Divide-by-zero constant 0xFFFFFFFF.
- Sub-module muldiv_step: combinational single iteration.
  - Multiply: add-if-LSB, then shift.
  - Divide: trial subtract and select.
  - Instantiated once and driven by the sequencer registers.

Test Plan:
- MULT A=7, B=0xFFFFFFFD, Start at t → Busy t+1..t+34; cycle t+35 HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done=1 for one cycle.
- DIVU A=100, B=7 → LO=14, HI=2. DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV and DIVU with B=0, A=0x12345678 → after 35 cycles LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, with ReadRequest_IN=1 from t+5 → Stall_OUT=1 through t+34 and 0 at t+35; HI=0xFFFFFFFE, LO=0x00000001. Start_IN pulsed at t+10 is ignored (Stall_OUT=1).
- IDLE: WriteHi=1, data 0xAAAA0000 → Hi_OUT=0xAAAA0000 next cycle. WriteLo with Start MULTU 3×4 on the same edge → LO=0xBBBB after 1 cycle, then LO=12, HI=0 at t+35.
- Start DIVU, assert RESET at t+15 for 1 cycle → immediately Busy=0, HI=LO=0, state IDLE, no Done pulse. A new MULTU 2×3 then completes normally (LO=6).

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer: operation and
// state encodings, default widths and the divide-by-zero quotient value.
package muldiv_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int COUNT_WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PREP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_FIXUP = 2'b11
    } md_state_e;

    // Quotient reported for a zero divisor (all ones).
    localparam logic [DATA_WIDTH_DEF-1:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// One combinational iteration of the unsigned multiply/divide datapath.
// Ports:
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi       : accumulator (multiply) or partial remainder (divide)
//   lo       : multiplier (multiply) or dividend/quotient (divide)
//   opnd     : multiplicand (multiply) or divisor (divide)
//   hi_next  : updated accumulator / remainder
//   lo_next  : updated multiplier / quotient
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] opnd,
    output logic [DATA_WIDTH-1:0] hi_next,
    output logic [DATA_WIDTH-1:0] lo_next
);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH+1:0] diff;

    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            // Shift the next dividend bit into the remainder, then trial
            // subtract; a clear top bit of diff means no borrow.
            shifted = {hi, lo[DATA_WIDTH-1]};
            diff    = {1'b0, shifted} - {2'b00, opnd};
            if (!diff[DATA_WIDTH+1]) begin
                hi_next = diff[DATA_WIDTH-1:0];
                lo_next = {lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[DATA_WIDTH-1:0];
                lo_next = {lo[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add if multiplier LSB is set, then shift {carry,acc,mplier} right.
            sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
            hi_next = sum[DATA_WIDTH:1];
            lo_next = {sum[0], lo[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle multiply/divide controller owning the HI/LO register pair.
// Ports:
//   CLOCK, RESET       : clock (rising edge), asynchronous active-high reset
//   Start_IN, Op_IN    : launch request and operation (MULT/MULTU/DIV/DIVU)
//   OperandA_IN/B_IN   : rs / rt operands, captured on the Start edge
//   WriteHi_IN/Lo_IN   : MTHI / MTLO write enables, WriteData_IN data
//   ReadRequest_IN     : decode stage holds an MFHI/MFLO
//   Hi_OUT, Lo_OUT     : architectural HI / LO registers
//   Busy_OUT           : operation in flight
//   Stall_OUT          : pipeline must hold its HI/LO access
//   Done_OUT           : one-cycle pulse after HI/LO were updated by an operation
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | accept Start and MTHI/MTLO writes
// ST_PREP  | take operand magnitudes, record result signs, load counter
// ST_RUN   | one datapath iteration per cycle, DATA_WIDTH cycles
// ST_FIXUP | apply sign / divide-by-zero fixup, write HI/LO
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  Start_IN,
    input  logic [1:0]            Op_IN,
    input  logic [DATA_WIDTH-1:0] OperandA_IN,
    input  logic [DATA_WIDTH-1:0] OperandB_IN,
    input  logic                  WriteHi_IN,
    input  logic                  WriteLo_IN,
    input  logic [DATA_WIDTH-1:0] WriteData_IN,
    input  logic                  ReadRequest_IN,
    output logic [DATA_WIDTH-1:0] Hi_OUT,
    output logic [DATA_WIDTH-1:0] Lo_OUT,
    output logic                  Busy_OUT,
    output logic                  Stall_OUT,
    output logic                  Done_OUT
);

    md_state_e               state_q;
    md_op_e                  op_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [DATA_WIDTH-1:0]   acc_q, work_q, opnd_q;
    logic                    neg_q, neg_r;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0]   hi_q, lo_q;
    logic                    busy_q, done_q;

    logic                    is_div, is_signed;
    logic [DATA_WIDTH-1:0]   a_mag, b_mag;
    logic [DATA_WIDTH-1:0]   step_hi, step_lo;
    logic [2*DATA_WIDTH-1:0] prod, prod_neg;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    // Unsigned result, so the magnitude of the most negative value is exact.
    assign a_mag = (is_signed && a_q[DATA_WIDTH-1]) ? -a_q : a_q;
    assign b_mag = (is_signed && b_q[DATA_WIDTH-1]) ? -b_q : b_q;

    assign prod     = {acc_q, work_q};
    assign prod_neg = -prod;

    muldiv_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .is_div (is_div),
        .hi     (acc_q),
        .lo     (work_q),
        .opnd   (opnd_q),
        .hi_next(step_hi),
        .lo_next(step_lo)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (WriteHi_IN) hi_q <= WriteData_IN;
                    if (WriteLo_IN) lo_q <= WriteData_IN;
                    if (Start_IN) begin
                        op_q    <= md_op_e'(Op_IN);
                        a_q     <= OperandA_IN;
                        b_q     <= OperandB_IN;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    acc_q   <= '0;
                    // Multiply iterates on the multiplier (B) with A as addend;
                    // divide iterates on the dividend (A) against divisor B.
                    work_q  <= is_div ? a_mag : b_mag;
                    opnd_q  <= is_div ? b_mag : a_mag;
                    neg_q   <= is_signed & (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1]);
                    neg_r   <= is_signed & a_q[DATA_WIDTH-1];
                    count_q <= COUNT_WIDTH'(DATA_WIDTH);
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    acc_q   <= step_hi;
                    work_q  <= step_lo;
                    count_q <= count_q - 1'b1;
                    if (count_q == COUNT_WIDTH'(1)) state_q <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    if (!is_div) begin
                        {hi_q, lo_q} <= neg_q ? prod_neg : prod;
                    end else if (b_q == '0) begin
                        lo_q <= DATA_WIDTH'($signed(DIV_ZERO_LO));
                        hi_q <= a_q;
                    end else begin
                        lo_q <= neg_q ? -work_q : work_q;
                        hi_q <= neg_r ? -acc_q : acc_q;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Hi_OUT    = hi_q;
    assign Lo_OUT    = lo_q;
    assign Busy_OUT  = busy_q;
    assign Done_OUT  = done_q;
    assign Stall_OUT = busy_q & (ReadRequest_IN | Start_IN | WriteHi_IN | WriteLo_IN);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Directed testbench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        Start_IN = 1'b0;
    logic [1:0]  Op_IN = 2'b00;
    logic [31:0] OperandA_IN = '0;
    logic [31:0] OperandB_IN = '0;
    logic        WriteHi_IN = 1'b0;
    logic        WriteLo_IN = 1'b0;
    logic [31:0] WriteData_IN = '0;
    logic        ReadRequest_IN = 1'b0;
    logic [31:0] Hi_OUT, Lo_OUT;
    logic        Busy_OUT, Stall_OUT, Done_OUT;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_sequencer dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .Start_IN      (Start_IN),
        .Op_IN         (Op_IN),
        .OperandA_IN   (OperandA_IN),
        .OperandB_IN   (OperandB_IN),
        .WriteHi_IN    (WriteHi_IN),
        .WriteLo_IN    (WriteLo_IN),
        .WriteData_IN  (WriteData_IN),
        .ReadRequest_IN(ReadRequest_IN),
        .Hi_OUT        (Hi_OUT),
        .Lo_OUT        (Lo_OUT),
        .Busy_OUT      (Busy_OUT),
        .Stall_OUT     (Stall_OUT),
        .Done_OUT      (Done_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation; returns HI/LO at the Done cycle and LO in cycle t+1.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic wlo, input logic [31:0] wdata, input string tag,
                          output logic [31:0] res_hi, output logic [31:0] res_lo,
                          output logic [31:0] lo_cycle1);
        int   lat;
        logic busy_ok;
        @(negedge CLOCK);
        Start_IN     = 1'b1;
        Op_IN        = op;
        OperandA_IN  = a;
        OperandB_IN  = b;
        WriteLo_IN   = wlo;
        WriteData_IN = wdata;
        @(negedge CLOCK);
        Start_IN    = 1'b0;
        WriteLo_IN  = 1'b0;
        OperandA_IN = $urandom;
        OperandB_IN = $urandom;
        Op_IN       = 2'($urandom);
        lo_cycle1   = Lo_OUT;
        lat         = 1;
        busy_ok     = 1'b1;
        while (Done_OUT !== 1'b1 && lat < 40) begin
            if (Busy_OUT !== 1'b1) busy_ok = 1'b0;
            @(negedge CLOCK);
            lat++;
        end
        check_val({tag, " latency"}, 64'(lat), 64'd35);
        check_val({tag, " busy window"}, 64'(busy_ok), 64'd1);
        check_val({tag, " busy at done"}, 64'(Busy_OUT), 64'd0);
        res_hi = Hi_OUT;
        res_lo = Lo_OUT;
        @(negedge CLOCK);
        check_val({tag, " done one cycle"}, 64'(Done_OUT), 64'd0);
    endtask

    initial begin
        logic [31:0] h, l, l1;
        logic        ok;

        #2;
        check_val("reset busy", 64'(Busy_OUT), 64'd0);
        check_val("reset done", 64'(Done_OUT), 64'd0);
        check_val("reset hi", 64'(Hi_OUT), 64'd0);
        check_val("reset lo", 64'(Lo_OUT), 64'd0);
        check_val("reset stall", 64'(Stall_OUT), 64'd0);
        @(negedge CLOCK);
        RESET = 1'b0;

        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, '0, "mult 7*-3", h, l, l1);
        check_val("mult 7*-3 hi", 64'(h), 64'hFFFF_FFFF);
        check_val("mult 7*-3 lo", 64'(l), 64'hFFFF_FFEB);

        run_op(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0, '0, "mult -5*-6", h, l, l1);
        check_val("mult -5*-6 hi", 64'(h), 64'h0);
        check_val("mult -5*-6 lo", 64'(l), 64'd30);

        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, '0, "divu 100/7", h, l, l1);
        check_val("divu 100/7 lo", 64'(l), 64'd14);
        check_val("divu 100/7 hi", 64'(h), 64'd2);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, "div -7/2", h, l, l1);
        check_val("div -7/2 lo", 64'(l), 64'hFFFF_FFFD);
        check_val("div -7/2 hi", 64'(h), 64'hFFFF_FFFF);

        run_op(OP_DIV, 32'h1234_5678, 32'd0, 1'b0, '0, "div by 0", h, l, l1);
        check_val("div by 0 lo", 64'(l), 64'hFFFF_FFFF);
        check_val("div by 0 hi", 64'(h), 64'h1234_5678);

        run_op(OP_DIVU, 32'h1234_5678, 32'd0, 1'b0, '0, "divu by 0", h, l, l1);
        check_val("divu by 0 lo", 64'(l), 64'hFFFF_FFFF);
        check_val("divu by 0 hi", 64'(h), 64'h1234_5678);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, "div min/-1", h, l, l1);
        check_val("div min/-1 lo", 64'(l), 64'h8000_0000);
        check_val("div min/-1 hi", 64'(h), 64'h0);

        // MULTU with a held MFHI/MFLO and a retried Start while busy
        @(negedge CLOCK);
        Start_IN    = 1'b1;
        Op_IN       = OP_MULTU;
        OperandA_IN = 32'hFFFF_FFFF;
        OperandB_IN = 32'hFFFF_FFFF;
        @(negedge CLOCK);
        ok = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            if (k >= 5) ReadRequest_IN = 1'b1;
            if (k == 10) begin
                Start_IN    = 1'b1;
                Op_IN       = OP_DIVU;
                OperandA_IN = 32'd5;
                OperandB_IN = 32'd1;
            end else begin
                Start_IN = 1'b0;
            end
            #1;
            if (k >= 5 && Stall_OUT !== 1'b1) ok = 1'b0;
            if (k < 5 && Stall_OUT !== 1'b0) ok = 1'b0;
            @(negedge CLOCK);
        end
        #1;
        check_val("stall window", 64'(ok), 64'd1);
        check_val("stall released", 64'(Stall_OUT), 64'd0);
        check_val("multu done", 64'(Done_OUT), 64'd1);
        check_val("multu max hi", 64'(Hi_OUT), 64'hFFFF_FFFE);
        check_val("multu max lo", 64'(Lo_OUT), 64'h0000_0001);
        ReadRequest_IN = 1'b0;
        @(negedge CLOCK);
        check_val("busy start ignored", 64'(Busy_OUT), 64'd0);

        // MTHI in idle, then MTLO coinciding with a Start
        WriteHi_IN   = 1'b1;
        WriteData_IN = 32'hAAAA_0000;
        @(negedge CLOCK);
        WriteHi_IN = 1'b0;
        check_val("mthi idle", 64'(Hi_OUT), 64'hAAAA_0000);

        run_op(OP_MULTU, 32'd3, 32'd4, 1'b1, 32'h0000_BBBB, "multu 3*4", h, l, l1);
        check_val("mtlo with start", 64'(l1), 64'h0000_BBBB);
        check_val("multu 3*4 lo", 64'(l), 64'd12);
        check_val("multu 3*4 hi", 64'(h), 64'd0);

        // Reset in the middle of a DIVU
        WriteHi_IN   = 1'b1;
        WriteData_IN = 32'h5555_0000;
        @(negedge CLOCK);
        WriteHi_IN  = 1'b0;
        Start_IN    = 1'b1;
        Op_IN       = OP_DIVU;
        OperandA_IN = 32'd1000;
        OperandB_IN = 32'd3;
        @(negedge CLOCK);
        Start_IN = 1'b0;
        repeat (14) @(negedge CLOCK);
        check_val("busy before reset", 64'(Busy_OUT), 64'd1);
        RESET = 1'b1;
        #1;
        check_val("midop reset busy", 64'(Busy_OUT), 64'd0);
        check_val("midop reset hi", 64'(Hi_OUT), 64'd0);
        check_val("midop reset lo", 64'(Lo_OUT), 64'd0);
        @(negedge CLOCK);
        RESET = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (Done_OUT !== 1'b0 || Busy_OUT !== 1'b0) ok = 1'b0;
            @(negedge CLOCK);
        end
        check_val("no done after reset", 64'(ok), 64'd1);

        run_op(OP_MULTU, 32'd2, 32'd3, 1'b0, '0, "multu 2*3", h, l, l1);
        check_val("multu 2*3 lo", 64'(l), 64'd6);
        check_val("multu 2*3 hi", 64'(h), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
